add_sched: RTL

ADD_SCHED -- requirements
Module: add_sched

---
 rtl/add_sched_pkg.sv | 19 +
 rtl/add_core.sv | 23 ++
 rtl/add_sched.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/add_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : add_sched_pkg                                                |
// | Description : Shared FSM state encoding and default widths for add_sched.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package add_sched_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int RES_W_DEF = 40;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

endpackage : add_sched_pkg
`default_nettype wire

// File: rtl/add_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : add_core                                                     |
// | Description : Plain WIDTH-bit adder with carry-in and carry-out.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module add_core #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   // One extra bit on each operand captures the carry out of the top bit.
   always_comb begin
      {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
   end

endmodule : add_core
`default_nettype wire

// File: rtl/add_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : add_sched                                                    |
// | Description : Two-requester scheduler in front of one shared adder.        |
// |               IDLE grants one requester, EXEC registers the sum, HOLD      |
// |               keeps the result until the consumer takes it.                |
// |               Define ADD_SCHED_PRIO_EN for fixed priority (requester 0     |
// |               always wins); otherwise arbitration is round-robin.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module add_sched
   import add_sched_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int RES_W = RES_W_DEF
) (
   input  logic             clk,
   input  logic             RST,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [RES_W-1:0] res_data,
   output logic             res_id,
   output logic             busy
);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               id_q, id_d;
   logic [RES_W-1:0]   res_data_q, res_data_d;
   logic               res_valid_q, res_valid_d;
   logic               res_id_q, res_id_d;
`ifndef ADD_SCHED_PRIO_EN
   logic               last_q, last_d;   // requester granted most recently
`endif

   logic               gnt0;
   logic               gnt1;
   logic [WIDTH-1:0]   core_sum;
   logic               core_cout;

   add_core #(
      .WIDTH (WIDTH)
   ) u_add_core (
      .a    (a_q),
      .b    (b_q),
      .cin  (1'b0),
      .sum  (core_sum),
      .cout (core_cout)
   );

   // Grant selection; ready is suppressed during reset even though the state reads IDLE.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!RST && (state_q == ST_IDLE)) begin
`ifdef ADD_SCHED_PRIO_EN
         gnt0 = req0_valid;
`else
         gnt0 = req0_valid && (!req1_valid || last_q);
`endif
         gnt1 = req1_valid && !gnt0;
      end
   end

   // Next-state and output logic for the IDLE/EXEC/HOLD sequencer.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      id_d        = id_q;
      res_data_d  = res_data_q;
      res_valid_d = res_valid_q;
      res_id_d    = res_id_q;
`ifndef ADD_SCHED_PRIO_EN
      last_d      = last_q;
`endif
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (gnt0 || gnt1) begin
               req0_ready = gnt0;
               req1_ready = gnt1;
               a_d        = gnt0 ? req0_a : req1_a;
               b_d        = gnt0 ? req0_b : req1_b;
               id_d       = gnt1;
`ifndef ADD_SCHED_PRIO_EN
               last_d     = gnt1;
`endif
               state_d    = ST_EXEC;
            end
         end
         ST_EXEC: begin
            res_data_d          = '0;
            res_data_d[WIDTH:0] = {core_cout, core_sum};
            res_valid_d         = 1'b1;
            res_id_d            = id_q;
            state_d             = ST_HOLD;
         end
         ST_HOLD: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset drops any in-flight operation.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= 1'b0;
         res_data_q  <= '0;
         res_valid_q <= 1'b0;
         res_id_q    <= 1'b0;
`ifndef ADD_SCHED_PRIO_EN
         last_q      <= 1'b1;   // requester 0 wins the first contention
`endif
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         id_q        <= id_d;
         res_data_q  <= res_data_d;
         res_valid_q <= res_valid_d;
         res_id_q    <= res_id_d;
`ifndef ADD_SCHED_PRIO_EN
         last_q      <= last_d;
`endif
      end
   end

   // Registered results and busy flag drive the outputs directly.
   always_comb begin
      res_valid = res_valid_q;
      res_data  = res_data_q;
      res_id    = res_id_q;
      busy      = (state_q != ST_IDLE);
   end

endmodule : add_sched
`default_nettype wire
